instruction_fetch: RTL and testbench

INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

---
 rtl/instruction_fetch.sv | 163 ++++++++++++++++
 tb/tb_instruction_fetch.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
//
// Issues sequential word fetches to an instruction memory, tracks the PCs of
// requests still waiting for a response, and buffers returned words in a small
// FIFO that feeds the decode stage. Branch/jump/trap redirects flush the FIFO
// and turn every in-flight request into a response to be dropped.
//
// Ports:
//   clk, rst          - clock; synchronous active-high reset
//   imem_req_valid    - fetch request valid (out)
//   imem_req_addr     - word-aligned fetch address (out)
//   imem_req_ready    - memory accepts the request (in)
//   imem_resp_valid   - in-order response valid (in)
//   imem_resp_data    - fetched instruction word (in)
//   redirect_valid    - one-cycle redirect pulse (in)
//   redirect_pc       - redirect target, low two bits ignored (in)
//   inst_valid        - FIFO head valid toward decode (out)
//   instruction       - instruction word at FIFO head (out)
//   pc_count          - PC of the FIFO head instruction (out)
//   inst_ready        - decode consumes the FIFO head (in)
// -----------------------------------------------------------------------------
module instruction_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] instruction,
  output logic [31:0] pc_count,
  input  logic        inst_ready
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fifo_entry_t;

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic [31:0] pcq_q [2];
  logic [31:0] pcq_d [2];
  logic [1:0]  outstanding_q, outstanding_d;
  // A slow memory can have two dropped requests still in flight when a second
  // redirect moves two more into this counter, so it is one bit wider than the
  // queue depth alone would suggest.
  logic [2:0]  drop_count_q, drop_count_d;
  fifo_entry_t fifo_q [2];
  fifo_entry_t fifo_d [2];
  logic [1:0]  fifo_count_q, fifo_count_d;

  logic        req_fire;
  logic        deq;
  logic        resp_accept;
  logic [2:0]  occupancy;
  logic [1:0]  pcq_level;
  logic [1:0]  fifo_level;
  logic        unused_redirect_bits;

  assign unused_redirect_bits = ^redirect_pc[1:0];

  assign inst_valid    = (fifo_count_q != 2'd0);
  assign instruction   = fifo_q[0].inst;
  assign pc_count      = fifo_q[0].pc;
  assign imem_req_addr = fetch_pc_q;

  assign deq = inst_valid && inst_ready;

  // Slots already claimed (in flight plus buffered), less the one decode frees
  // this cycle. Capping this at 2 is what keeps the FIFO from overflowing.
  assign occupancy = {1'b0, outstanding_q} + {1'b0, fifo_count_q} - {2'b00, deq};

  assign imem_req_valid = !rst && !redirect_valid && (occupancy < 3'd2);
  assign req_fire       = imem_req_valid && imem_req_ready;

  // Responses only belong to the current path once every stale one has drained.
  assign resp_accept = imem_resp_valid && !redirect_valid && (drop_count_q == 3'd0);

  // Both queues are shift registers with the head at index 0: pop shifts,
  // push writes the first free slot after the pop, so push+pop keeps order.
  assign pcq_level  = outstanding_q - {1'b0, resp_accept};
  assign fifo_level = fifo_count_q - {1'b0, deq};

  // NOTE: every signal gets a default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    pcq_d         = pcq_q;
    outstanding_d = outstanding_q;
    drop_count_d  = drop_count_q;
    fifo_d        = fifo_q;
    fifo_count_d  = fifo_count_q;

    if (redirect_valid) begin
      fetch_pc_d    = {redirect_pc[31:2], 2'b00};
      outstanding_d = 2'd0;
      fifo_count_d  = 2'd0;
      // A response arriving this cycle answers one of the in-flight requests.
      drop_count_d  = drop_count_q + {1'b0, outstanding_q} - {2'b00, imem_resp_valid};
    end else begin
      if (req_fire) begin
        fetch_pc_d = fetch_pc_q + 32'd4;
      end

      if (imem_resp_valid && (drop_count_q != 3'd0)) begin
        drop_count_d = drop_count_q - 3'd1;
      end

      if (resp_accept) begin
        pcq_d[0] = pcq_q[1];
      end
      if (req_fire) begin
        pcq_d[pcq_level[0]] = fetch_pc_q;
      end
      outstanding_d = outstanding_q + {1'b0, req_fire} - {1'b0, resp_accept};

      if (deq) begin
        fifo_d[0] = fifo_q[1];
      end
      if (resp_accept) begin
        fifo_d[fifo_level[0]] = '{pc: pcq_q[0], inst: imem_resp_data};
      end
      fifo_count_d = fifo_count_q + {1'b0, resp_accept} - {1'b0, deq};
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q    <= RESET_PC;
      outstanding_q <= 2'd0;
      drop_count_q  <= 3'd0;
      fifo_count_q  <= 2'd0;
      // NOTE: the storage is reset too because the FIFO head drives
      // instruction/pc_count directly and must read as zero during reset.
      pcq_q[0]      <= '0;
      pcq_q[1]      <= '0;
      fifo_q[0]     <= '0;
      fifo_q[1]     <= '0;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      pcq_q         <= pcq_d;
      outstanding_q <= outstanding_d;
      drop_count_q  <= drop_count_d;
      fifo_q        <= fifo_d;
      fifo_count_q  <= fifo_count_d;
    end
  end

  // A response with nothing in flight means the memory model is broken.
  a_resp_has_request : assert property (
    @(posedge clk) disable iff (rst)
      !(imem_resp_valid && (outstanding_q == 2'd0) && (drop_count_q == 3'd0))
  ) else $error("instruction_fetch: response with no request in flight");

endmodule

// File: tb/tb_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_instruction_fetch
//
// Directed bench for instruction_fetch. A small in-order memory model with a
// selectable latency answers accepted requests with data = addr ^ DATA_KEY, so
// every delivered instruction can be checked against its PC.
// -----------------------------------------------------------------------------
module tb_instruction_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_1000;
  localparam logic [31:0] DATA_KEY = 32'hC0DE_5A00;

  logic        clk;
  logic        rst;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic [31:0] instruction;
  logic [31:0] pc_count;
  logic        inst_ready;

  instruction_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk             (clk),
    .rst             (rst),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_resp_valid (imem_resp_valid),
    .imem_resp_data  (imem_resp_data),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .inst_valid      (inst_valid),
    .instruction     (instruction),
    .pc_count        (pc_count),
    .inst_ready      (inst_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  int mem_lat  = 1;
  int fire_cnt = 0;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } mem_req_t;

  mem_req_t mq[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle: sample the request handshake, clock, then let the memory
  // model drive this cycle's response just after the edge.
  task automatic tick();
    logic        fire;
    logic [31:0] faddr;
    logic        rstv;
    #1;
    fire  = imem_req_valid && imem_req_ready;
    faddr = imem_req_addr;
    rstv  = rst;
    if (fire) fire_cnt++;
    @(posedge clk);
    cyc++;
    if (rstv) mq.delete();
    else if (fire) mq.push_back('{addr: faddr, due: cyc + mem_lat - 1});
    #1;
    if (mq.size() != 0 && mq[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mq[0].addr ^ DATA_KEY;
      void'(mq.pop_front());
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = 32'h0;
    end
  endtask

  task automatic wait_inst(input string tag, input int budget);
    int n;
    n = 0;
    while (!inst_valid && n < budget) begin
      tick();
      n++;
    end
    check({tag, "_timeout"}, 32'(inst_valid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst             = 1'b1;
    imem_req_ready  = 1'b1;
    imem_resp_valid = 1'b0;
    imem_resp_data  = 32'h0;
    redirect_valid  = 1'b0;
    redirect_pc     = 32'h0;
    inst_ready      = 1'b1;
    tick();
    tick();

    // Reset values.
    check("rst_req_valid",   32'(imem_req_valid), 32'd0);
    check("rst_inst_valid",  32'(inst_valid),     32'd0);
    check("rst_instruction", instruction,         32'd0);
    check("rst_pc_count",    pc_count,            32'd0);

    // Streaming from reset release, one-cycle memory, decode always ready.
    rst = 1'b0;
    #1;
    check("first_req_valid", 32'(imem_req_valid), 32'd1);
    check("first_req_addr",  imem_req_addr,        RESET_PC);
    tick();
    check("c1_inst_valid", 32'(inst_valid), 32'd0);
    check("c1_req_addr",   imem_req_addr,   RESET_PC + 32'd4);
    tick();
    for (int i = 0; i < 4; i++) begin
      check("stream_valid", 32'(inst_valid), 32'd1);
      check("stream_pc",    pc_count,        RESET_PC + 32'(4 * i));
      check("stream_inst",  instruction,     (RESET_PC + 32'(4 * i)) ^ DATA_KEY);
      check("stream_addr",  imem_req_addr,   RESET_PC + 32'(4 * (i + 2)));
      tick();
    end

    // Decode stalled for five cycles, then released.
    rst = 1'b1;
    tick();
    rst        = 1'b0;
    inst_ready = 1'b0;
    fire_cnt   = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (i >= 1) begin
        check("stall_valid", 32'(inst_valid), 32'd1);
        check("stall_pc",    pc_count,        RESET_PC);
        check("stall_inst",  instruction,     RESET_PC ^ DATA_KEY);
      end
    end
    check("stall_reqs_le2", 32'(fire_cnt <= 2), 32'd1);
    inst_ready = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      check("release_valid", 32'(inst_valid), 32'd1);
      check("release_pc",    pc_count,        RESET_PC + 32'(4 * i));
      tick();
    end

    // Redirect with two requests outstanding (base+8, base+12).
    mem_lat = 1;
    rst     = 1'b1;
    tick();
    rst        = 1'b0;
    inst_ready = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    check("full_req_valid", 32'(imem_req_valid), 32'd0);
    mem_lat    = 3;
    inst_ready = 1'b1;
    #1;
    check("drain_req_valid0", 32'(imem_req_valid), 32'd1);
    check("drain_req_addr0",  imem_req_addr,        RESET_PC + 32'd8);
    tick();
    check("drain_req_addr1",  imem_req_addr,        RESET_PC + 32'd12);
    check("drain_pc1",        pc_count,             RESET_PC + 32'd4);
    tick();
    check("two_out_inst_valid", 32'(inst_valid),     32'd0);
    check("two_out_req_valid",  32'(imem_req_valid), 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    #1;
    check("redir_req_valid", 32'(imem_req_valid), 32'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    check("post_redir_req_valid",  32'(imem_req_valid), 32'd1);
    check("post_redir_req_addr",   imem_req_addr,        32'h0000_0100);
    check("post_redir_inst_valid", 32'(inst_valid),      32'd0);
    wait_inst("drop_wait", 12);
    check("drop_first_pc",   pc_count,    32'h0000_0100);
    check("drop_first_inst", instruction, 32'h0000_0100 ^ DATA_KEY);
    tick();
    check("drop_second_pc",  pc_count,    32'h0000_0104);

    // Redirect colliding with a response and a consuming handshake; target
    // has its low bits set.
    mem_lat = 1;
    rst     = 1'b1;
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    check("coll_pc_before", pc_count, RESET_PC + 32'd4);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0203;
    #1;
    check("coll_req_valid", 32'(imem_req_valid), 32'd0);
    tick();
    redirect_valid = 1'b0;
    #1;
    check("coll_fifo_empty", 32'(inst_valid),     32'd0);
    check("coll_req_valid2", 32'(imem_req_valid), 32'd1);
    check("coll_req_addr",   imem_req_addr,        32'h0000_0200);
    wait_inst("coll_wait", 6);
    check("coll_first_pc",  pc_count, 32'h0000_0200);
    tick();
    check("coll_second_pc", pc_count, 32'h0000_0204);

    // Address wrap at the top of the 32-bit space.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    #1;
    check("wrap_addr_top", imem_req_addr, 32'hFFFF_FFFC);
    tick();
    check("wrap_addr_zero", imem_req_addr, 32'h0000_0000);
    wait_inst("wrap_wait", 6);
    check("wrap_pc_top",  pc_count, 32'hFFFF_FFFC);
    tick();
    check("wrap_pc_zero",   pc_count,    32'h0000_0000);
    check("wrap_inst_zero", instruction, DATA_KEY);

    // Reset with the FIFO full.
    inst_ready = 1'b0;
    tick();
    tick();
    check("pre_rst_valid",     32'(inst_valid),     32'd1);
    check("pre_rst_req_valid", 32'(imem_req_valid), 32'd0);
    rst = 1'b1;
    tick();
    check("mid_rst_req_valid",   32'(imem_req_valid), 32'd0);
    check("mid_rst_inst_valid",  32'(inst_valid),     32'd0);
    check("mid_rst_instruction", instruction,         32'd0);
    check("mid_rst_pc_count",    pc_count,            32'd0);
    rst        = 1'b0;
    inst_ready = 1'b1;
    #1;
    check("post_rst_req_addr", imem_req_addr, RESET_PC);
    wait_inst("post_rst_wait", 6);
    check("post_rst_pc",   pc_count,    RESET_PC);
    check("post_rst_inst", instruction, RESET_PC ^ DATA_KEY);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
